// File: rtl/fp_core_pkg.sv
// Shared unsigned fixed-point definitions: rounding modes and word-length helper.
package fp_core_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_HALF_UP = 2'd1,
        RND_CONV    = 2'd2
    } round_mode_e;

    function automatic int ufp_wl(input int iw, input int qw);
        return iw + qw;
    endfunction

endpackage

// File: rtl/clip_unsigned.sv
// Unsigned integer-width reduction: saturate (CLIP=1) or wrap, zero-extend if wider.
module clip_unsigned #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8,
    parameter bit CLIP  = 1'b1
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             clip
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            logic over;
            assign over    = |in_val[IN_W-1:OUT_W];
            assign clip    = CLIP && over;
            assign out_val = clip ? '1 : in_val[OUT_W-1:0];
        end else begin : g_wide
            assign out_val = OUT_W'(in_val);
            assign clip    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ufp_round_lane.sv
// One lane of the fraction stage: aligns IN_QW to OUT_QW with the selected rounding.
module ufp_round_lane
    import fp_core_pkg::*;
#(
    parameter int          IN_IW  = 8,
    parameter int          IN_QW  = 8,
    parameter int          OUT_QW = 4,
    parameter round_mode_e MODE   = RND_TRUNC
) (
    input  logic [ufp_wl(IN_IW, IN_QW)-1:0] in_val,
    output logic [IN_IW+OUT_QW:0]           tmp
);

    localparam int TW = IN_IW + OUT_QW + 1;

    generate
        if (OUT_QW >= IN_QW) begin : g_pad
            assign tmp = TW'(in_val) << (OUT_QW - IN_QW);
        end else begin : g_rnd
            localparam int DW = IN_QW - OUT_QW;
            localparam int KW = TW - 1;

            logic [KW-1:0] kept;
            logic [DW-1:0] dropped;
            logic [DW-1:0] rest;
            logic          inc;

            assign kept    = in_val[IN_IW+IN_QW-1:DW];
            assign dropped = in_val[DW-1:0];
            // Dropped bits below the half-LSB; nonzero means strictly above one half.
            assign rest    = dropped << 1;

            // NOTE: every path assigns inc (default arm), so no latch is inferred.
            always_comb begin
                case (MODE)
                    RND_HALF_UP: inc = dropped[DW-1];
                    RND_CONV:    inc = dropped[DW-1] && ((|rest) || kept[0]);
                    default:     inc = 1'b0;
                endcase
            end

            assign tmp = TW'(kept) + TW'(inc);
        end
    endgenerate

endmodule

// File: rtl/ufp_resize_pipe.sv
// Two-stage valid/ready ufp resizer over N_CH lanes with clip statistics.
module ufp_resize_pipe
    import fp_core_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int IN_IW  = 8,
    parameter int IN_QW  = 8,
    parameter int OUT_IW = 4,
    parameter int OUT_QW = 4,
    parameter int ROUND  = 0,
    parameter int CLIP   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_CH*ufp_wl(IN_IW, IN_QW)-1:0]   in_val,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [N_CH*ufp_wl(OUT_IW, OUT_QW)-1:0] out_val,
    output logic [N_CH-1:0]                        out_clip,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_CH-1:0]                        clip_sticky,
    output logic [CNT_W-1:0]                       clip_count,
    input  logic                                   stat_clear
);

    localparam int INW = ufp_wl(IN_IW, IN_QW);
    localparam int OW  = ufp_wl(OUT_IW, OUT_QW);
    localparam int TW  = IN_IW + OUT_QW + 1;

    logic [N_CH*TW-1:0] tmp_c;
    logic [N_CH*TW-1:0] s1_q;
    logic [N_CH*OW-1:0] res_c;
    logic [N_CH-1:0]    clip_c;
    logic               v1;
    logic               ld1;
    logic               ld2;
    logic               xfer;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            ufp_round_lane #(
                .IN_IW (IN_IW),
                .IN_QW (IN_QW),
                .OUT_QW(OUT_QW),
                .MODE  (round_mode_e'(ROUND))
            ) u_round (
                .in_val(in_val[k*INW +: INW]),
                .tmp   (tmp_c[k*TW +: TW])
            );

            clip_unsigned #(
                .IN_W (TW),
                .OUT_W(OW),
                .CLIP (CLIP != 0)
            ) u_clip (
                .in_val (s1_q[k*TW +: TW]),
                .out_val(res_c[k*OW +: OW]),
                .clip   (clip_c[k])
            );
        end
    endgenerate

    // A stage loads when empty or when its successor is draining this cycle.
    assign ld2      = !out_valid || out_ready;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset as well so out_val/out_clip read 0 after reset.
            v1          <= 1'b0;
            s1_q        <= '0;
            out_valid   <= 1'b0;
            out_val     <= '0;
            out_clip    <= '0;
            clip_sticky <= '0;
            clip_count  <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= tmp_c;
            end
            if (ld2) begin
                out_valid <= v1;
                if (v1) begin
                    out_val  <= res_c;
                    out_clip <= clip_c;
                end
            end
            // Clear takes priority, but a same-cycle transfer is still recorded.
            if (stat_clear) begin
                clip_sticky <= xfer ? out_clip : '0;
                clip_count  <= CNT_W'(xfer && (|out_clip));
            end else if (xfer) begin
                clip_sticky <= clip_sticky | out_clip;
                if ((|out_clip) && (clip_count != '1)) clip_count <= clip_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ufp_resize_pipe.sv
// Bench: five resizer configurations on one shared stimulus, checked against an arithmetic model.
module tb_ufp_resize_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        stat_clear;
    logic [31:0] in_val;
    logic [15:0] in_val4;

    logic        irdy   [5];
    logic        ovalid [5];
    logic [15:0] ov     [4];
    logic [31:0] ov4;
    logic [3:0]  oc     [5];
    logic [3:0]  sticky [5];
    logic [1:0]  cnt    [5];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;
    bit bp_en    = 1'b0;
    int bp_cyc   = 0;

    logic [31:0] q [$];
    logic [3:0]  m_sticky [5];
    logic [1:0]  m_cnt    [5];

    always #5 clk = ~clk;

    assign in_val4 = {in_val[27:24], in_val[19:16], in_val[11:8], in_val[3:0]};

    // u0: truncate/clip, u1: half-up/clip, u2: convergent/clip, u3: half-up/wrap (4.4 -> 2.2)
    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            ufp_resize_pipe #(
                .N_CH(4), .IN_IW(4), .IN_QW(4), .OUT_IW(2), .OUT_QW(2),
                .ROUND((g == 3) ? 1 : g), .CLIP((g == 3) ? 0 : 1), .CNT_W(2)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_val     (in_val),
                .in_valid   (in_valid),
                .in_ready   (irdy[g]),
                .out_val    (ov[g]),
                .out_clip   (oc[g]),
                .out_valid  (ovalid[g]),
                .out_ready  (out_ready),
                .clip_sticky(sticky[g]),
                .clip_count (cnt[g]),
                .stat_clear (stat_clear)
            );
        end
    endgenerate

    // u4: 2.2 -> 4.4, exercises fraction padding and integer zero-extension
    ufp_resize_pipe #(
        .N_CH(4), .IN_IW(2), .IN_QW(2), .OUT_IW(4), .OUT_QW(4),
        .ROUND(0), .CLIP(1), .CNT_W(2)
    ) u_pad (
        .clk        (clk),
        .rst        (rst),
        .in_val     (in_val4),
        .in_valid   (in_valid),
        .in_ready   (irdy[4]),
        .out_val    (ov4),
        .out_clip   (oc[4]),
        .out_valid  (ovalid[4]),
        .out_ready  (out_ready),
        .clip_sticky(sticky[4]),
        .clip_count (cnt[4]),
        .stat_clear (stat_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Real-valued view: lane value x/16 rescaled to quarters is x/4; round, then range-limit to 0..15.
    function automatic logic [19:0] model_lane4(input logic [31:0] v, input int mode, input bit clip_en);
        logic [15:0] o = '0;
        logic [3:0]  c = '0;
        for (int k = 0; k < 4; k++) begin
            int x;
            int qv;
            int r;
            x  = int'(v[k*8 +: 8]);
            qv = x / 4;
            r  = x % 4;
            if (mode == 1 && r >= 2) qv = qv + 1;
            else if (mode == 2 && (r > 2 || (r == 2 && (qv % 2) == 1))) qv = qv + 1;
            if (qv > 15) begin
                if (clip_en) begin
                    qv   = 15;
                    c[k] = 1'b1;
                end else begin
                    qv = qv % 16;
                end
            end
            o[k*4 +: 4] = 4'(qv);
        end
        return {c, o};
    endfunction

    function automatic logic [31:0] model_pad(input logic [31:0] v);
        logic [31:0] o = '0;
        for (int k = 0; k < 4; k++) o[k*8 +: 8] = 8'(int'(v[k*8 +: 4]) * 4);
        return o;
    endfunction

    // Compare process: inputs change just after posedge, so everything is stable here.
    always @(negedge clk) begin
        logic [19:0] e;
        logic [3:0]  ec [5];
        logic [31:0] b;
        bit          xf;
        if (chk_en) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("u%0d_sticky", i), 32'(sticky[i]), 32'(m_sticky[i]));
                check($sformatf("u%0d_count", i), 32'(cnt[i]), 32'(m_cnt[i]));
                check($sformatf("u%0d_in_ready", i), 32'(irdy[i]),
                      32'(!(q.size() == 2 && !out_ready)));
            end
            if (rst) begin
                q.delete();
                for (int i = 0; i < 5; i++) begin
                    m_sticky[i] = '0;
                    m_cnt[i]    = '0;
                end
            end else begin
                xf = ovalid[0] && out_ready;
                for (int i = 0; i < 5; i++) ec[i] = '0;
                if (xf) begin
                    check("xfer_has_beat", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        b = q.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            e = model_lane4(b, (i == 3) ? 1 : i, i != 3);
                            check($sformatf("u%0d_val", i), 32'(ov[i]), 32'(e[15:0]));
                            check($sformatf("u%0d_clip", i), 32'(oc[i]), 32'(e[19:16]));
                            ec[i] = e[19:16];
                        end
                        check("u4_val", ov4, model_pad(b));
                        check("u4_clip", 32'(oc[4]), 0);
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (stat_clear) begin
                        m_sticky[i] = ec[i];
                        m_cnt[i]    = (ec[i] != 0) ? 2'd1 : 2'd0;
                    end else begin
                        m_sticky[i] = m_sticky[i] | ec[i];
                        if (ec[i] != 0 && m_cnt[i] != 2'd3) m_cnt[i] = m_cnt[i] + 2'd1;
                    end
                end
                if (in_valid && irdy[0]) q.push_back(in_val);
            end
        end
    end

    task automatic send(input logic [31:0] v);
        bit acc = 1'b0;
        int n   = 0;
        in_val   = v;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = irdy[0];
            @(posedge clk);
            #1;
            n++;
            if (bp_en) begin
                bp_cyc++;
                out_ready = (bp_cyc % 4 == 0) || (bp_cyc % 4 == 3);
            end
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(q.size()), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ovalid[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_valid", 32'(ovalid[0]), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] stream [8];
        int lat;
        stream = '{32'h3F222627, 32'h01025006, 32'h0A0B0E12, 32'hFF000203,
                   32'h31323334, 32'h1E1A1612, 32'h40000000, 32'h0D0C0B0A};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0; in_val = '0;
        for (int i = 0; i < 5; i++) begin
            m_sticky[i] = '0;
            m_cnt[i]    = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_out_valid", 32'(ovalid[0]), 0);
        check("rst_in_ready", 32'(irdy[0]), 1);
        check("rst_out_val", 32'(ov[0]), 0);
        check("rst_sticky", 32'(sticky[0]), 0);
        check("rst_count", 32'(cnt[0]), 0);

        // Rounding modes on lanes 0x27, 0x26, 0x22, 0x3F; two-cycle latency
        send(32'h3F222627);
        lat = 1;
        while (!ovalid[0] && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 2);
        check("trunc_val", 32'(ov[0]), 32'h0000F899);
        check("halfup_val", 32'(ov[1]), 32'h0000F9AA);
        check("halfup_clip", 32'(oc[1]), 32'h8);
        check("conv_val", 32'(ov[2]), 32'h0000F8AA);
        check("wrap_val", 32'(ov[3]), 32'h000009AA);
        check("wrap_clip", 32'(oc[3]), 0);
        check("pad_val", ov4, 32'h3C08181C);
        drain();

        // Only lane 2 overflows
        send(32'h00501001);
        drain();
        check("lane2_sticky", 32'(sticky[0]), 32'h4);
        check("lane2_count", 32'(cnt[0]), 1);

        // Backpressure stream with out_ready 1,0,0,1,...
        bp_en = 1'b1;
        bp_cyc = 0;
        for (int i = 0; i < 8; i++) send(stream[i]);
        bp_en = 1'b0;
        drain();

        // Counter saturation at 2^CNT_W-1
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        check("clear_count", 32'(cnt[0]), 0);
        for (int i = 0; i < 5; i++) send(32'h000000FF);
        drain();
        check("sat_count", 32'(cnt[0]), 3);
        check("sat_sticky", 32'(sticky[0]), 32'h1);

        // Held output under backpressure, then clear concurrent with a clipping transfer
        out_ready = 1'b0;
        send(32'h00005000);
        wait_valid();
        @(posedge clk);
        #1;
        check("hold_valid", 32'(ovalid[0]), 1);
        check("hold_val", 32'(ov[0]), 32'h00F0);
        stat_clear = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        check("clr_xfer_count", 32'(cnt[0]), 1);
        check("clr_xfer_sticky", 32'(sticky[0]), 32'h2);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'h11111111);
        send(32'h22222222);
        check("full_in_ready", 32'(irdy[0]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("flush_valid", 32'(ovalid[0]), 0);
        check("flush_sticky", 32'(sticky[0]), 0);
        check("flush_count", 32'(cnt[0]), 0);
        out_ready = 1'b1;
        send(32'h08040201);
        drain();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
